// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter and transfer sequencer for two bus masters.
// Ownership lasts one whole burst. Burst length comes from the granted master's
// control word, and beats are qualified by the slave's ready signal.
// A stall watchdog revokes ownership after TIMEOUT consecutive ready-low cycles.
module bus_arbiter_rr #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [8:0] m0_control,
  input  logic [8:0] m1_control,
  input  logic       ready,
  output logic [1:0] ack,
  output logic       mux_sel,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] ST_START = 2'b00;
  localparam logic [1:0] ST_CONT  = 2'b01;
  localparam logic [1:0] ST_IDLE  = 2'b10;
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_XFER,
    S_HANDOVER
  } state_t;

  state_t     state;
  logic       last;
  logic       page_mode;
  logic [6:0] beat_cnt;
  logic [7:0] stall_cnt;

  logic [8:0] ctl;
  logic [1:0] status;
  logic [2:0] burst;
  logic [6:0] len_m1;
  logic       data_beat;
  logic       start_beat;
  logic       stall_hit;
  logic       winner;
  logic       unused_ctl_bits;

  // Decode the granted master's control word and pick the round-robin winner.
  always_comb begin
    ctl        = mux_sel ? m1_control : m0_control;
    status     = ctl[8:7];
    burst      = ctl[5:3];
    len_m1     = (7'd1 << burst) - 7'd1;
    data_beat  = ready && ((status == ST_START) || (status == ST_CONT));
    start_beat = ready && (status == ST_START);
    stall_hit  = !ready && (stall_cnt == STALL_LAST);
    winner     = (req == 2'b11) ? ~last : req[1];
  end

  // Bit 6 (burst MSB), size and WE do not affect arbitration.
  assign unused_ctl_bits = ^{ctl[6], ctl[2:0]};

  // Arbitration FSM with registered grant, mux select, busy and timeout pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ack       <= 2'b00;
      mux_sel   <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      last      <= 1'b1;
      page_mode <= 1'b0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          stall_cnt <= '0;
          if (req != 2'b00) begin
            state   <= S_GRANT;
            ack     <= winner ? 2'b10 : 2'b01;
            mux_sel <= winner;
            busy    <= 1'b1;
          end
        end

        S_GRANT: begin
          stall_cnt <= ready ? 8'd0 : stall_cnt + 8'd1;
          if (start_beat) begin
            // A completed START beat wins over a request drop in the same cycle.
            page_mode <= (burst == 3'b111);
            beat_cnt  <= (burst == 3'b111) ? 7'd0 : len_m1;
            if (burst == 3'b000) begin
              state <= S_HANDOVER;
              ack   <= 2'b00;
              busy  <= 1'b0;
            end else begin
              state <= S_XFER;
            end
          end else if (!req[mux_sel]) begin
            state <= S_HANDOVER;
            ack   <= 2'b00;
            busy  <= 1'b0;
          end else if (stall_hit) begin
            state   <= S_HANDOVER;
            ack     <= 2'b00;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end

        S_XFER: begin
          stall_cnt <= ready ? 8'd0 : stall_cnt + 8'd1;
          if (page_mode && (status == ST_IDLE)) begin
            state <= S_HANDOVER;
            ack   <= 2'b00;
            busy  <= 1'b0;
          end else if (!page_mode && data_beat) begin
            beat_cnt <= beat_cnt - 7'd1;
            if (beat_cnt == 7'd1) begin
              state <= S_HANDOVER;
              ack   <= 2'b00;
              busy  <= 1'b0;
            end
          end else if (stall_hit) begin
            state   <= S_HANDOVER;
            ack     <= 2'b00;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end

        S_HANDOVER: begin
          // Turnaround cycle: remember who was served so the other master goes next.
          last      <= mux_sel;
          stall_cnt <= '0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus randomized
// bursts checked against a transaction-level round-robin/beat-count model.
module tb_bus_arbiter_rr;

  localparam int TO = 16;
  localparam logic [1:0] S_START = 2'b00;
  localparam logic [1:0] S_CONT  = 2'b01;
  localparam logic [1:0] S_IDLE  = 2'b10;
  localparam logic [1:0] S_BUSY  = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [8:0] m0_control = '0;
  logic [8:0] m1_control = '0;
  logic       ready = 1'b0;
  logic [1:0] ack;
  logic       mux_sel;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Burst-8 stall table: 3 beats, 3 stalls, 2 BUSY cycles, 5 beats.
  logic [1:0] st_tab [13] = '{S_START, S_CONT, S_CONT, S_CONT, S_CONT, S_CONT,
                              S_BUSY, S_BUSY, S_CONT, S_CONT, S_CONT, S_CONT, S_CONT};
  logic       rd_tab [13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  bus_arbiter_rr #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .m0_control (m0_control),
    .m1_control (m1_control),
    .ready      (ready),
    .ack        (ack),
    .mux_sel    (mux_sel),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] mk_ctl(input logic [1:0] st, input logic [2:0] code,
                                        input logic [1:0] size, input logic we);
    return {st, 1'b0, code, size, we};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic m, input logic [8:0] v);
    if (m) m1_control = v;
    else   m0_control = v;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    req = 2'b00;
    ready = 1'b0;
    m0_control = mk_ctl(S_IDLE, 3'b000, 2'b00, 1'b0);
    m1_control = mk_ctl(S_IDLE, 3'b000, 2'b00, 1'b0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int run;
    int r;
    logic [1:0] rq;
    logic [1:0] onehot;
    logic       model_last;
    logic       w;
    logic [2:0] code;
    int         len;

    // ---------------- reset state ----------------
    reset = 1'b0;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", 32'(ack), 0);
    check("reset_mux", 32'(mux_sel), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_timeout", 32'(timeout), 0);
    $display("txn reset: ack=%b busy=%b", ack, busy);
    reset = 1'b1;

    // ---------------- burst-4 write, master 0 ----------------
    m0_control = mk_ctl(S_IDLE, 3'b010, 2'b10, 1'b1);
    req = 2'b01;
    tick();
    check("b4_grant_ack", 32'(ack), 1);
    check("b4_grant_busy", 32'(busy), 1);
    check("b4_grant_mux", 32'(mux_sel), 0);
    m0_control = mk_ctl(S_START, 3'b010, 2'b10, 1'b1);
    for (int b = 1; b <= 4; b++) begin
      if (b == 4) req = 2'b00;
      tick();
      check("b4_beat_ack", 32'(ack), (b < 4) ? 1 : 0);
      check("b4_beat_busy", 32'(busy), (b < 4) ? 1 : 0);
      m0_control = mk_ctl(S_CONT, 3'b010, 2'b10, 1'b1);
    end
    m0_control = mk_ctl(S_IDLE, 3'b010, 2'b10, 1'b1);
    tick();
    check("b4_idle_ack", 32'(ack), 0);
    check("b4_idle_busy", 32'(busy), 0);
    $display("txn burst4_m0: done ack=%b", ack);

    // ---------------- alternating burst-1 ----------------
    do_reset();
    m0_control = mk_ctl(S_START, 3'b000, 2'b00, 1'b1);
    m1_control = mk_ctl(S_START, 3'b000, 2'b00, 1'b1);
    ready = 1'b1;
    req = 2'b11;
    begin
      logic [1:0] exp_ack [7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
      logic       exp_mux [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
        tick();
        check("alt_ack", 32'(ack), 32'(exp_ack[i]));
        check("alt_mux", 32'(mux_sel), 32'(exp_mux[i]));
        $display("txn alternate step %0d: ack=%b mux_sel=%b", i, ack, mux_sel);
      end
    end

    // ---------------- burst-8 halfword with stall and BUSY ----------------
    do_reset();
    m0_control = mk_ctl(S_IDLE, 3'b011, 2'b01, 1'b0);
    req = 2'b01;
    tick();
    check("b8_grant_ack", 32'(ack), 1);
    cnt = 0;
    for (int i = 0; i < 13; i++) begin
      m0_control = mk_ctl(st_tab[i], 3'b011, 2'b01, 1'b0);
      ready = rd_tab[i];
      if (i == 1) req = 2'b00;
      if (rd_tab[i] && (st_tab[i] == S_START || st_tab[i] == S_CONT)) cnt++;
      tick();
      check("b8_ack", 32'(ack), (cnt == 8) ? 0 : 1);
      check("b8_timeout", 32'(timeout), 0);
    end
    tick();
    check("b8_idle_ack", 32'(ack), 0);
    $display("txn burst8_stall: beats=%0d ack=%b", cnt, ack);

    // ---------------- page mode, master 1 ----------------
    do_reset();
    m1_control = mk_ctl(S_IDLE, 3'b111, 2'b10, 1'b1);
    req = 2'b10;
    tick();
    check("pg_grant_ack", 32'(ack), 2);
    check("pg_grant_mux", 32'(mux_sel), 1);
    cnt = 0;
    run = 0;
    while (cnt < 20) begin
      m1_control = mk_ctl((cnt == 0) ? S_START : S_CONT, 3'b111, 2'b10, 1'b1);
      ready = (run < 8) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (cnt >= 1) req = 2'b00;
      if (ready) begin
        cnt++;
        run = 0;
      end else begin
        run++;
      end
      tick();
      check("pg_hold_ack", 32'(ack), 2);
    end
    m1_control = mk_ctl(S_IDLE, 3'b111, 2'b10, 1'b1);
    tick();
    check("pg_end_ack", 32'(ack), 0);
    check("pg_end_timeout", 32'(timeout), 0);
    $display("txn page_mode: beats=%0d ack=%b", cnt, ack);

    // ---------------- timeout ----------------
    do_reset();
    m0_control = mk_ctl(S_START, 3'b100, 2'b10, 1'b0);
    m1_control = mk_ctl(S_START, 3'b000, 2'b10, 1'b0);
    ready = 1'b1;
    req = 2'b11;
    tick();
    check("to_grant_ack", 32'(ack), 1);
    tick();
    check("to_start_ack", 32'(ack), 1);
    ready = 1'b0;
    m0_control = mk_ctl(S_CONT, 3'b100, 2'b10, 1'b0);
    for (int i = 1; i <= TO; i++) begin
      tick();
      check("to_stall_timeout", 32'(timeout), (i == TO) ? 1 : 0);
      check("to_stall_ack", 32'(ack), (i == TO) ? 0 : 1);
    end
    tick();
    check("to_pulse_end", 32'(timeout), 0);
    check("to_idle_ack", 32'(ack), 0);
    ready = 1'b1;
    tick();
    check("to_next_ack", 32'(ack), 2);
    check("to_next_mux", 32'(mux_sel), 1);
    $display("txn timeout: next ack=%b", ack);

    // ---------------- asynchronous reset mid burst-16 ----------------
    do_reset();
    m0_control = mk_ctl(S_START, 3'b100, 2'b10, 1'b1);
    ready = 1'b1;
    req = 2'b01;
    tick();
    tick();
    m0_control = mk_ctl(S_CONT, 3'b100, 2'b10, 1'b1);
    tick();
    tick();
    check("ar_pre_ack", 32'(ack), 1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_ack", 32'(ack), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_timeout", 32'(timeout), 0);
    tick();
    reset = 1'b1;
    m0_control = mk_ctl(S_START, 3'b000, 2'b10, 1'b1);
    m1_control = mk_ctl(S_START, 3'b000, 2'b10, 1'b1);
    req = 2'b11;
    tick();
    check("ar_first_ack", 32'(ack), 1);
    $display("txn async_reset: first grant ack=%b", ack);

    // ---------------- randomized bursts vs reference model ----------------
    do_reset();
    model_last = 1'b1;
    for (int t = 0; t < 40; t++) begin
      rq = 2'($urandom_range(1, 3));
      w = (rq == 2'b11) ? ~model_last : (rq == 2'b10);
      onehot = w ? 2'b10 : 2'b01;
      code = 3'($urandom_range(0, 6));
      len = 1 << code;
      req = rq;
      set_ctl(w, mk_ctl(S_IDLE, code, 2'b10, 1'b0));
      set_ctl(~w, 9'($urandom));
      ready = 1'($urandom);
      tick();
      check("rnd_grant_ack", 32'(ack), 32'(onehot));
      check("rnd_grant_mux", 32'(mux_sel), 32'(w));
      check("rnd_grant_busy", 32'(busy), 1);
      cnt = 0;
      run = 0;
      while (cnt < len) begin
        r = $urandom_range(0, 9);
        set_ctl(~w, 9'($urandom));
        if (cnt >= 1) req[~w] = 1'($urandom);
        if (r < 2 && run < 10) begin
          set_ctl(w, mk_ctl((cnt == 0) ? S_START : S_CONT, code, 2'b10, 1'b0));
          ready = 1'b0;
          run++;
        end else if (r < 3) begin
          set_ctl(w, mk_ctl(S_BUSY, code, 2'b10, 1'b0));
          ready = 1'b1;
          run = 0;
        end else begin
          set_ctl(w, mk_ctl((cnt == 0) ? S_START : S_CONT, code, 2'b10, 1'b0));
          ready = 1'b1;
          run = 0;
          cnt++;
        end
        tick();
        check("rnd_beat_ack", 32'(ack), (cnt == len) ? 0 : 32'(onehot));
        check("rnd_timeout", 32'(timeout), 0);
      end
      set_ctl(w, mk_ctl(S_IDLE, code, 2'b10, 1'b0));
      tick();
      check("rnd_turn_ack", 32'(ack), 0);
      check("rnd_turn_busy", 32'(busy), 0);
      model_last = w;
      $display("txn random %0d: req=%b master=%0d beats=%0d", t, rq, w, len);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin arbiter and transfer sequencer for the shared unidirectional system bus in front of the SDRAM slave. It takes bus requests from two masters and issues a one-hot grant (`ack`). It drives the select for the address/control/write-data mux and holds ownership for exactly one complete burst, tracked from the granted master's 9-bit control word and the slave's `Ready`. It replaces the fixed-priority grant logic feeding `arbiter_req`/`arbiter_ack` in the top module.

## Interface
Parameters:
- `TIMEOUT`, 255: consecutive `ready`-low cycles during a transfer before ownership is forcibly revoked; legal range 2..255.

Ports:
- `clk`  in  1  bus clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); one clock, no other resets.
- `req`  in  2  bus request, bit i = master i; level-sensitive.
- `m0_control`  in  9  master 0 control: [8:7] status, [6:3] burst, [2:1] size, [0] WE.
- `m1_control`  in  9  master 1 control, same format.
- `ready`  in  1  slave `Ready`; a data beat completes on an edge where `ready`=1.
- `ack`  out  2  one-hot grant, registered.
- `mux_sel`  out  1  index of the master driving the bus mux; valid while `busy`=1.
- `busy`  out  1  bus owned (state GRANT or XFER).
- `timeout`  out  1  one-cycle pulse when a transfer is aborted by timeout.

## Operation
- Status encoding: START=00, CONT=01, IDLE=10, BUSY=11.
- Burst code is control[5:3]; bit 6 is ignored.
  - Beat length: 000→1, 001→2, 010→4, 011→8, 100→16, 101→32, 110→64.
  - 111 = page mode: no fixed length.
- The beat counter is 7 bits. It is loaded with length−1 when the START beat completes and decrements on each completed CONT beat.
- A beat is counted only when `ready`=1 and the granted status is START or CONT.
  - BUSY and IDLE cycles never count, even when `ready`=1.
- Round-robin pointer `last` holds the most recently granted master; the other master has priority. Reset value: `last`=1, so master 0 wins first.
- FSM states:
  - IDLE: `ack`=00. If any `req` bit is set, grant the winner and go to GRANT. If none, stay.
  - GRANT: ownership given; waiting for the master's START beat.
    - Granted `req` drops before START completes → HANDOVER with no beat counted.
    - START beat completes with length 1 → HANDOVER.
    - START beat completes otherwise → XFER.
  - XFER: burst in progress.
    - Counter reaches 0 on a completed beat → HANDOVER.
    - Page mode: go to HANDOVER on the first cycle the granted status is IDLE.
  - HANDOVER: `ack`=00 for exactly one turnaround cycle. Update `last` to the master just served, then go to IDLE.
- Timeout: in GRANT or XFER, a counter counts consecutive `ready`=0 cycles and clears whenever `ready`=1.
  - When it reaches `TIMEOUT`, pulse `timeout` for one cycle and go to HANDOVER.
  - `last` is updated as for a normal completion.
- `mux_sel` follows the grant and holds its last value in IDLE and HANDOVER.
- A master that keeps `req` high after its burst competes again; with both requesting, grants alternate strictly 0,1,0,1.
- While granted, the other master's `req` and control are ignored.

## Timing
- Reset (`reset`=0), applied immediately and asynchronously: `ack`=00, `mux_sel`=0, `busy`=0, `timeout`=0, FSM=IDLE, `last`=1, both counters 0.
- Reset mid-burst aborts the transfer with no `timeout` pulse.
- Request to grant latency: `req` sampled high in IDLE at edge N gives `ack` valid after edge N.
- The master drives START from the cycle after `ack` rises.
- The last beat completes at edge M:
  - `ack`=00 after M (HANDOVER).
  - IDLE after M+1.
  - The next grant is visible after M+2 at the earliest.
- The minimum bus turnaround between bursts of different masters is 2 idle cycles.
- `busy`, `ack` and `mux_sel` are all registered and change only on the same edges.
- The `timeout` pulse coincides with `ack` going to 00.

## Test plan
- Burst-4 word write, master 0 only, `ready`=1 throughout:
  - `req`=01 at edge 0 → `ack`=01 after edge 1.
  - START plus 3 CONT beats.
  - `ack`=00 for exactly one cycle after the 4th beat, then IDLE.
- Both `req`=11 immediately after reset release, each master doing burst-1 (`req` held high):
  - `ack` sequence is 01, 00, (IDLE), 10, 00, (IDLE), 01.
  - `mux_sel` tracks the grant.
- Burst-8 halfword with `ready` held low for 3 cycles after beat 3, plus 2 BUSY-status cycles with `ready`=1:
  - Counter does not move during the stall or the BUSY cycles.
  - `ack` is held until the 8th counted beat.
  - No `timeout`.
- Page-mode burst (code 111) of 20 beats, then status IDLE → `ack` drops on the edge after IDLE is first sampled.
- `TIMEOUT`=16 with `ready` held 0 after START:
  - `timeout`=1 for one cycle on the 16th stalled edge, together with `ack`=00.
  - Master 1 is granted next if requesting.
- `reset` driven low mid burst-16 → `ack`=00 and `busy`=0 immediately, without waiting for an edge. After release, master 0 wins the first arbitration.
